output_unit_team1: RTL
======================

Name: output_unit_team1

Overview:
- Output-side counterpart of the INPR/FGI input path in the basic-computer datapath.
- On the OUT instruction strobe, captures AC[7:0] into OUTR and clears FGO.
- Shifts OUTR out on a serial line as an 8N1 frame (1 start, 8 data LSB-first, 1 stop), then sets FGO again.
- The control unit reads FGO for SKO and for the output interrupt request.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit period; legal range 1..65535.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
out_AC  input  8  AC[7:0] from the accumulator.
OUT_C  input  1  OUT instruction strobe from control (B[10] & p); sampled on clk.
OUTR  output  8  output register; holds the byte being or last transmitted.
FGO  output  1  output flag; 1 = ready for a new byte, 0 = transmitting.
tx  output  1  serial line; idles high.
busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE, OUTR = 0, FGO = 1, tx = 1, busy = 0, baud counter = 0, bit counter = 0.
- Reset asserted mid-frame:
  - Aborts the frame and forces the same values immediately, without waiting for a clock edge.
  - No partial bits are sent after release.
- All outputs are registered; no combinational path from inputs to outputs.
- Accept rule:
  - OUT_C = 1 and FGO = 1 at a rising edge: OUTR <= out_AC, FGO <= 0, state <= START, tx <= 0, busy <= 1, baud counter <= 0.
  - tx therefore falls at the edge that samples OUT_C, i.e. one cycle after the strobe is first presented.
- OUT_C = 1 while FGO = 0 is ignored:
  - OUTR, the frame and all counters are unchanged.
  - There is no queueing; software must poll FGO via SKO.
- OUT_C held high for several cycles: only the first edge with FGO = 1 is accepted.
- States:
  - IDLE: tx = 1; waits for an accepted OUT_C.
  - START: tx = 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx = OUTR[bit index] for CLKS_PER_BIT cycles per bit.
    - Bit index increments 0..7.
    - After bit 7 completes, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles.
    - On the final cycle's edge: state <= IDLE, FGO <= 1, busy <= 0.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Wraps to 0 at every bit boundary.
  - Width is the minimum holding CLKS_PER_BIT-1, at least 1 bit.
- Bit counter: 3 bits; it must not overflow into a 9th data bit.
- Frame length: exactly 10*CLKS_PER_BIT cycles from tx falling to FGO rising.
- Earliest next accept:
  - The edge after FGO rises.
  - OUT_C on the same edge where FGO is being set is ignored, because FGO is still 0 at that edge.
- Back-to-back accepted frames have one cycle of idle-high tx between the stop bit and the next start bit (when OUT_C is asserted immediately).
- OUTR is stable for the whole frame; out_AC changes after acceptance have no effect.
- CLKS_PER_BIT = 1 is legal and gives one cycle per bit.

Test Plan:
1. Reset values: assert rst asynchronously between edges -> OUTR = 0x00, FGO = 1, tx = 1, busy = 0 without any clk edge.
2. Single frame, CLKS_PER_BIT = 4, out_AC = 0xA5, OUT_C pulsed one cycle -> OUTR = 0xA5, FGO = 0 after the edge.
   - tx holds 0,1,0,1,0,0,1,0,1,1 for 4 cycles each (start, LSB-first data, stop).
   - FGO = 1 exactly 40 cycles after tx fell.
3. Busy rejection: during the frame of test 2, present out_AC = 0x3C with OUT_C = 1 at bit 3 -> OUTR stays 0xA5, tx waveform unchanged, frame length still 40 cycles.
4. Held strobe and back-to-back, CLKS_PER_BIT = 2:
   - OUT_C held high continuously, out_AC = 0x01 then 0xFF -> first frame sends 0x01.
   - Exactly one idle-high cycle follows the stop bit, then a frame sending 0xFF.
   - FGO is low for 20 cycles in each frame.
5. Reset mid-frame, CLKS_PER_BIT = 4, byte 0x00: assert rst during data bit 2 -> tx = 1 and FGO = 1 immediately.
   - After release, tx stays high until a new OUT_C.
   - A new OUT_C with 0x55 produces a complete clean frame.
6. CLKS_PER_BIT = 1, out_AC = 0x80 -> tx sequence 0,0,0,0,0,0,0,0,1,1 over 10 cycles; FGO returns high on the 10th edge.

Source files
------------

// File: rtl/output_unit_team1_if.sv
// ============================================================================
//  Module      : output_unit_team1_if
//  Description : Bus bundle between the basic-computer control/datapath and
//                the serial output unit.
//                  out_AC : AC[7:0] presented for capture
//                  OUT_C  : OUT instruction strobe (B[10] & p)
//                  OUTR   : output register contents
//                  FGO    : output flag, 1 = ready for a new byte
//                  tx     : serial line, idles high
//                  busy   : 1 whenever a frame is in progress
//                master = control/datapath side, slave = output unit side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface output_unit_team1_if;
    logic [7:0] out_AC;
    logic       OUT_C;
    logic [7:0] OUTR;
    logic       FGO;
    logic       tx;
    logic       busy;

    modport master (
        output out_AC,
        output OUT_C,
        input  OUTR,
        input  FGO,
        input  tx,
        input  busy
    );

    modport slave (
        input  out_AC,
        input  OUT_C,
        output OUTR,
        output FGO,
        output tx,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/output_unit_team1.sv
// ============================================================================
//  Module      : output_unit_team1
//  Description : Output-side counterpart of the INPR/FGI input path. An OUT
//                strobe seen while FGO = 1 captures AC[7:0] into OUTR, clears
//                FGO and transmits OUTR as an 8N1 frame (start, 8 data bits
//                LSB first, stop). FGO is set again when the stop bit ends.
//  Parameters  : CLKS_PER_BIT - clk cycles per serial bit (1..65535)
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - output_unit_team1_if.slave (out_AC, OUT_C in;
//                       OUTR, FGO, tx, busy out, all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_unit_team1 #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output_unit_team1_if.slave    bus
);

    // Baud counter holds 0..CLKS_PER_BIT-1; keep at least one bit so the
    // CLKS_PER_BIT = 1 case still has a legal vector.
    localparam int               BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state,    next_state;
    logic [7:0]         outr,     next_outr;
    logic               fgo,      next_fgo;
    logic               tx,       next_tx;
    logic               busy,     next_busy;
    logic [BAUD_W-1:0]  baud_cnt, next_baud_cnt;
    logic [2:0]         bit_cnt,  next_bit_cnt;

    logic               bit_done;

    assign bit_done = (baud_cnt == BAUD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            outr     <= 8'h00;
            fgo      <= 1'b1;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
        end else begin
            state    <= next_state;
            outr     <= next_outr;
            fgo      <= next_fgo;
            tx       <= next_tx;
            busy     <= next_busy;
            baud_cnt <= next_baud_cnt;
            bit_cnt  <= next_bit_cnt;
        end
    end

    // tx is registered, so each transition loads the level of the bit that
    // starts at this edge rather than the one that is ending.
    always_comb begin
        next_state    = state;
        next_outr     = outr;
        next_fgo      = fgo;
        next_tx       = tx;
        next_busy     = busy;
        next_baud_cnt = baud_cnt;
        next_bit_cnt  = bit_cnt;

        case (state)
            IDLE: begin
                next_tx = 1'b1;
                // fgo is the registered flag, so a strobe on the edge that
                // sets it again is still rejected.
                if (bus.OUT_C && fgo) begin
                    next_outr     = bus.out_AC;
                    next_fgo      = 1'b0;
                    next_state    = START;
                    next_tx       = 1'b0;
                    next_busy     = 1'b1;
                    next_baud_cnt = '0;
                end
            end

            START: begin
                if (bit_done) begin
                    next_baud_cnt = '0;
                    next_state    = DATA;
                    next_bit_cnt  = 3'd0;
                    next_tx       = outr[0];
                end else begin
                    next_baud_cnt = baud_cnt + BAUD_W'(1);
                end
            end

            DATA: begin
                if (bit_done) begin
                    next_baud_cnt = '0;
                    if (bit_cnt == 3'd7) begin
                        // Bit counter saturates at 7; never a 9th data bit.
                        next_state = STOP;
                        next_tx    = 1'b1;
                    end else begin
                        next_bit_cnt = bit_cnt + 3'd1;
                        next_tx      = outr[bit_cnt + 3'd1];
                    end
                end else begin
                    next_baud_cnt = baud_cnt + BAUD_W'(1);
                end
            end

            STOP: begin
                next_tx = 1'b1;
                if (bit_done) begin
                    next_baud_cnt = '0;
                    next_bit_cnt  = 3'd0;
                    next_state    = IDLE;
                    next_fgo      = 1'b1;
                    next_busy     = 1'b0;
                end else begin
                    next_baud_cnt = baud_cnt + BAUD_W'(1);
                end
            end

            default: begin
                next_state = IDLE;
                next_tx    = 1'b1;
                next_fgo   = 1'b1;
                next_busy  = 1'b0;
            end
        endcase
    end

    assign bus.OUTR = outr;
    assign bus.FGO  = fgo;
    assign bus.tx   = tx;
    assign bus.busy = busy;

endmodule

`default_nettype wire
